// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: FSM encodings, ALU in_sel codes
// and the packed command record width.
package alu_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_LOAD  = 2'b01;
   localparam logic [1:0] ST_HOLD  = 2'b10;
   localparam logic [1:0] ST_CLEAR = 2'b11;

   // in_sel is {persist, load, reset}
   localparam logic [2:0] IN_SEL_IDLE    = 3'b000;
   localparam logic [2:0] IN_SEL_RESET   = 3'b001;
   localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
   localparam logic [2:0] IN_SEL_PERSIST = 3'b100;

   // Command record is {clr, num1, num2, op}
   function automatic int unsigned cmd_rec_w(input int unsigned width, input int unsigned opw);
      return 1 + 2 * width + opw;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer: DEPTH entries (power of 2), first-word
// fall-through read port, push ignored when full, pop ignored when empty.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int unsigned DW    = 23,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rd_q];

   // Fullness is judged before this cycle's pop, so a pop never frees a slot early
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands and plays each one to the ALU as load -> persist, then captures
// the ALU result after HOLD_CYCLES. Optional ALU_OPCHK_EN discards non-one-hot opcodes.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned OPW         = 7,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned HOLD_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             on,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_clr,
   input  logic [WIDTH-1:0] cmd_num1,
   input  logic [WIDTH-1:0] cmd_num2,
   input  logic [OPW-1:0]   cmd_op,
   output logic             alu_on,
   output logic [2:0]       alu_in_sel,
   output logic [WIDTH-1:0] alu_num1,
   output logic [WIDTH-1:0] alu_num2,
   output logic [OPW-1:0]   alu_out_sel,
   input  logic [WIDTH-1:0] alu_out,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic [1:0]       seq_state,
   output logic             op_err
);

   localparam int unsigned CMD_W = cmd_rec_w(WIDTH, OPW);
   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   logic [CMD_W-1:0] head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             head_clr;
   logic [WIDTH-1:0] head_num1;
   logic [WIDTH-1:0] head_num2;
   logic [OPW-1:0]   head_op;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       in_sel_q, in_sel_d;
   logic [WIDTH-1:0] num1_q, num1_d;
   logic [WIDTH-1:0] num2_q, num2_d;
   logic [OPW-1:0]   op_q, op_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;

   alu_cmd_fifo #(
      .DW    (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (cmd_valid),
      .pop_i   (pop),
      .wdata_i ({cmd_clr, cmd_num1, cmd_num2, cmd_op}),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_clr  = head[CMD_W-1];
   assign head_num1 = head[CMD_W-2 -: WIDTH];
   assign head_num2 = head[OPW+WIDTH-1 -: WIDTH];
   assign head_op   = head[OPW-1:0];

   assign cmd_ready   = !fifo_full;
   assign alu_on      = on;
   assign alu_in_sel  = in_sel_q;
   assign alu_num1    = num1_q;
   assign alu_num2    = num2_q;
   assign alu_out_sel = op_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign seq_state   = state_q;

`ifdef ALU_OPCHK_EN
   logic op_err_q, op_err_d;
   logic head_onehot;

   assign head_onehot = (head_op != '0) && ((head_op & (head_op - OPW'(1))) == '0);
   assign op_err      = op_err_q;
`else
   assign op_err = 1'b0;
`endif

   // The ALU-facing outputs are registered alongside the state, so freezing the
   // state while on==0 also freezes everything the ALU sees.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      in_sel_d    = in_sel_q;
      num1_d      = num1_q;
      num2_d      = num2_q;
      op_d        = op_q;
      res_data_d  = res_data_q;
      res_valid_d = 1'b0;
      pop         = 1'b0;
`ifdef ALU_OPCHK_EN
      op_err_d    = op_err_q;
`endif
      if (on) begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  if (head_clr) begin
                     state_d  = ST_CLEAR;
                     in_sel_d = IN_SEL_RESET;
`ifdef ALU_OPCHK_EN
                  end else if (!head_onehot) begin
                     pop      = 1'b1;
                     op_err_d = 1'b1;
`endif
                  end else begin
                     state_d  = ST_LOAD;
                     in_sel_d = IN_SEL_LOAD;
                     num1_d   = head_num1;
                     num2_d   = head_num2;
                     op_d     = head_op;
                  end
               end
            end
            ST_LOAD: begin
               state_d  = ST_HOLD;
               in_sel_d = IN_SEL_PERSIST;
               cnt_d    = CNT_W'(HOLD_CYCLES - 1);
            end
            ST_HOLD: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  res_data_d  = alu_out;
                  res_valid_d = 1'b1;
                  pop         = 1'b1;
                  state_d     = ST_IDLE;
                  in_sel_d    = IN_SEL_IDLE;
               end
            end
            default: begin
               pop      = 1'b1;
               state_d  = ST_IDLE;
               in_sel_d = IN_SEL_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         in_sel_q    <= IN_SEL_IDLE;
         num1_q      <= '0;
         num2_q      <= '0;
         op_q        <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_sel_q    <= in_sel_d;
         num1_q      <= num1_d;
         num2_q      <= num2_d;
         op_q        <= op_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

`ifdef ALU_OPCHK_EN
   always_ff @(posedge clk) begin
      if (!rst) op_err_q <= 1'b0;
      else      op_err_q <= op_err_d;
   end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed timing steps plus a random
// command stream checked against a queue-based reference. Honours ALU_OPCHK_EN.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       on;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_clr;
   logic [7:0] cmd_num1;
   logic [7:0] cmd_num2;
   logic [6:0] cmd_op;
   logic       alu_on;
   logic [2:0] alu_in_sel;
   logic [7:0] alu_num1;
   logic [7:0] alu_num2;
   logic [6:0] alu_out_sel;
   logic [7:0] alu_out;
   logic       res_valid;
   logic [7:0] res_data;
   logic [1:0] seq_state;
   logic       op_err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc_n  = 0;

   logic [7:0] exp_q[$];
   logic [7:0] t3_n1 [4] = '{8'h11, 8'hF0, 8'h3C, 8'h80};
   logic [7:0] t3_n2 [4] = '{8'h22, 8'h0F, 8'h5A, 8'h81};
   logic [6:0] t3_op [4] = '{7'b1000000, 7'b0010000, 7'b0000100, 7'b0100000};
   int unsigned j;
   logic        accepted;
   logic        acc_clr;
   logic [7:0]  acc_val;

   // Behavioural ALU the sequencer drives
   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [6:0] op);
      if (op[6])      return a + b;
      else if (op[5]) return a - b;
      else if (op[4]) return a & b;
      else if (op[3]) return a | b;
      else if (op[2]) return a ^ b;
      else if (op[1]) return ~a;
      else if (op[0]) return a;
      else            return 8'h00;
   endfunction

   assign alu_out = alu_f(alu_num1, alu_num2, alu_out_sel);

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .WIDTH       (8),
      .OPW         (7),
      .DEPTH       (4),
      .HOLD_CYCLES (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .on          (on),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_clr     (cmd_clr),
      .cmd_num1    (cmd_num1),
      .cmd_num2    (cmd_num2),
      .cmd_op      (cmd_op),
      .alu_on      (alu_on),
      .alu_in_sel  (alu_in_sel),
      .alu_num1    (alu_num1),
      .alu_num2    (alu_num2),
      .alu_out_sel (alu_out_sel),
      .alu_out     (alu_out),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .seq_state   (seq_state),
      .op_err      (op_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc_n);
      end
   endtask

   task automatic offer(input logic clr, input logic [7:0] a, input logic [7:0] b,
                        input logic [6:0] op);
      cmd_valid = 1'b1;
      cmd_clr   = clr;
      cmd_num1  = a;
      cmd_num2  = b;
      cmd_op    = op;
   endtask

   initial begin
      rst = 1'b0; on = 1'b0; cmd_valid = 1'b0; cmd_clr = 1'b0;
      cmd_num1 = '0; cmd_num2 = '0; cmd_op = '0;

      // Reset
      cyc(); cyc();
      chk("rst_state", 32'(seq_state), 32'd0);
      chk("rst_insel", 32'(alu_in_sel), 32'd0);
      chk("rst_num1", 32'(alu_num1), 32'd0);
      chk("rst_num2", 32'(alu_num2), 32'd0);
      chk("rst_outsel", 32'(alu_out_sel), 32'd0);
      chk("rst_resvalid", 32'(res_valid), 32'd0);
      chk("rst_resdata", 32'(res_data), 32'd0);
      chk("rst_alu_on", 32'(alu_on), 32'd0);
      chk("rst_op_err", 32'(op_err), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b1; on = 1'b1;
      cyc();
      chk("alu_on_fwd", 32'(alu_on), 32'd1);

      // Single command: 0x57 + 0x1A
      offer(1'b0, 8'h57, 8'h1A, 7'b1000000);
      cyc(); cmd_valid = 1'b0;
      chk("t2_idle", 32'(seq_state), 32'd0);
      cyc();
      chk("t2_load_sel", 32'(alu_in_sel), 32'b010);
      chk("t2_load_state", 32'(seq_state), 32'd1);
      chk("t2_num1", 32'(alu_num1), 32'h57);
      chk("t2_num2", 32'(alu_num2), 32'h1A);
      chk("t2_op", 32'(alu_out_sel), 32'b1000000);
      for (int unsigned i = 0; i < 3; i++) begin
         cyc();
         chk("t2_hold_sel", 32'(alu_in_sel), 32'b100);
         chk("t2_hold_novalid", 32'(res_valid), 32'd0);
      end
      cyc();
      chk("t2_res_valid", 32'(res_valid), 32'd1);
      chk("t2_res_data", 32'(res_data), 32'h71);
      chk("t2_back_idle", 32'(alu_in_sel), 32'd0);
      cyc();
      chk("t2_pulse_end", 32'(res_valid), 32'd0);
      chk("t2_data_held", 32'(res_data), 32'h71);

      // Five back-to-back offers into a 4-deep FIFO: fifth is refused
      for (int unsigned i = 0; i < 5; i++) begin
         if (i < 4) offer(1'b0, t3_n1[i], t3_n2[i], t3_op[i]);
         else       offer(1'b0, 8'hAA, 8'h55, 7'b1000000);
         chk("t3_ready", 32'(cmd_ready), 32'(i < 4));
         cyc();
      end
      cmd_valid = 1'b0;
      j = 0;
      for (int unsigned t = 5; t <= 21; t++) begin
         cyc();
         chk("t3_valid", 32'(res_valid), 32'((t % 5 == 0) && (t <= 20)));
         if (res_valid && j < 4) begin
            chk("t3_data", 32'(res_data), 32'(alu_f(t3_n1[j], t3_n2[j], t3_op[j])));
            j++;
         end
      end
      chk("t3_count", j, 32'd4);

      // ALU clear followed by a normal command
      offer(1'b1, 8'hFF, 8'hFF, 7'b1000000);
      cyc();
      offer(1'b0, 8'h02, 8'h04, 7'b1000000);
      chk("t4_idle", 32'(seq_state), 32'd0);
      cyc(); cmd_valid = 1'b0;
      chk("t4_clear_state", 32'(seq_state), 32'd3);
      chk("t4_clear_sel", 32'(alu_in_sel), 32'b001);
      chk("t4_clear_novalid", 32'(res_valid), 32'd0);
      cyc();
      chk("t4_after_clr_sel", 32'(alu_in_sel), 32'd0);
      chk("t4_after_clr_novalid", 32'(res_valid), 32'd0);
      cyc();
      chk("t4_load_sel", 32'(alu_in_sel), 32'b010);
      chk("t4_num1", 32'(alu_num1), 32'h02);
      chk("t4_num2", 32'(alu_num2), 32'h04);
      for (int unsigned i = 0; i < 3; i++) begin
         cyc();
         chk("t4_hold_sel", 32'(alu_in_sel), 32'b100);
         chk("t4_hold_novalid", 32'(res_valid), 32'd0);
      end
      cyc();
      chk("t4_res_valid", 32'(res_valid), 32'd1);
      chk("t4_res_data", 32'(res_data), 32'h06);

      // on dropped for 4 cycles while in HOLD
      offer(1'b0, 8'h30, 8'h05, 7'b0100000);
      cyc(); cmd_valid = 1'b0;
      cyc(); cyc(); cyc();
      chk("t5_in_hold", 32'(seq_state), 32'd2);
      on = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         cyc();
         chk("t5_frozen_sel", 32'(alu_in_sel), 32'b100);
         chk("t5_frozen_state", 32'(seq_state), 32'd2);
         chk("t5_alu_off", 32'(alu_on), 32'd0);
         chk("t5_novalid", 32'(res_valid), 32'd0);
      end
      on = 1'b1;
      cyc();
      chk("t5_resume_novalid", 32'(res_valid), 32'd0);
      cyc();
      chk("t5_res_valid", 32'(res_valid), 32'd1);
      chk("t5_res_data", 32'(res_data), 32'h2B);

      // Reset in the middle of an operation drops everything
      offer(1'b0, 8'h01, 8'h01, 7'b1000000);
      cyc();
      offer(1'b0, 8'h02, 8'h02, 7'b1000000);
      cyc(); cmd_valid = 1'b0;
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      chk("rmid_state", 32'(seq_state), 32'd0);
      chk("rmid_sel", 32'(alu_in_sel), 32'd0);
      chk("rmid_ready", 32'(cmd_ready), 32'd1);
      for (int unsigned i = 0; i < 8; i++) begin
         cyc();
         chk("rmid_novalid", 32'(res_valid), 32'd0);
         chk("rmid_idle", 32'(seq_state), 32'd0);
      end

`ifdef ALU_OPCHK_EN
      offer(1'b0, 8'h01, 8'h02, 7'b1100000);
      cyc(); cmd_valid = 1'b0;
      cyc();
      chk("t6_op_err", 32'(op_err), 32'd1);
      chk("t6_no_load_state", 32'(seq_state), 32'd0);
      chk("t6_no_load_sel", 32'(alu_in_sel), 32'd0);
      offer(1'b0, 8'h10, 8'h03, 7'b0001000);
      cyc(); cmd_valid = 1'b0;
      cyc();
      chk("t6_load_sel", 32'(alu_in_sel), 32'b010);
      cyc(); cyc(); cyc(); cyc();
      chk("t6_res_valid", 32'(res_valid), 32'd1);
      chk("t6_res_data", 32'(res_data), 32'h13);
      chk("t6_sticky", 32'(op_err), 32'd1);
`else
      chk("t6_op_err_tied", 32'(op_err), 32'd0);
`endif

      // Random stream against the in-order result queue
      exp_q.delete();
      for (int unsigned c = 0; c < 400; c++) begin
         on        = ($urandom_range(0, 7) != 0);
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_clr   = ($urandom_range(0, 7) == 0);
         cmd_num1  = 8'($urandom);
         cmd_num2  = 8'($urandom);
         cmd_op    = 7'(1 << $urandom_range(0, 6));
         accepted  = cmd_valid && cmd_ready;
         acc_clr   = cmd_clr;
         acc_val   = alu_f(cmd_num1, cmd_num2, cmd_op);
         cyc();
         if (accepted && !acc_clr) exp_q.push_back(acc_val);
         chk("rnd_alu_on", 32'(alu_on), 32'(on));
         if (res_valid) begin
            chk("rnd_expected_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("rnd_data", 32'(res_data), 32'(exp_q.pop_front()));
         end
      end
      on = 1'b1; cmd_valid = 1'b0;
      for (int unsigned c = 0; c < 100 && exp_q.size() > 0; c++) begin
         cyc();
         if (res_valid) begin
            chk("drain_data", 32'(res_data), 32'(exp_q.pop_front()));
         end
      end
      chk("drain_done", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
